// File: rtl/head_package.sv
// Shared types and constants for the head record path.
//   s_head        : one input record, valid qualifies a 4-bit nibble
//   s_head_frame  : packed frame word plus fill count
//   e_pack_state  : frame packer FSM states
package head_package;

    localparam int unsigned HDSIZE    = 8;   // nibbles per frame
    localparam int unsigned HDTIMEOUT = 16;  // idle cycles before a partial frame is emitted

    typedef struct packed {
        logic       valid;
        logic [3:0] idata;
    } s_head;

    typedef struct packed {
        logic [HDSIZE*4-1:0] data;
        logic [3:0]          count;
    } s_head_frame;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } e_pack_state;

endpackage

// File: rtl/head_idle_timer.sv
// Saturating idle counter.
//   clock, rst : clock and synchronous active-high reset
//   clear      : force the count to zero (dominates enable)
//   enable     : count up by one, saturating at LIMIT
//   hit        : the count takes the value LIMIT at the coming edge
module head_idle_timer #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned W     = 8
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    logic [W-1:0] count;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count != W'(LIMIT))) begin
            count_next = count + W'(1);
        end
    end

    // Looking at the next value lets the owner act on the same edge the count saturates.
    assign hit = (count_next == W'(LIMIT));

    always_ff @(posedge clock) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/head_frame_packer.sv
// Packs s_head nibble records into a HDSIZE-nibble frame and hands it downstream
// with a valid/ready handshake. Partial frames leave on flush or idle timeout.
//   clock, rst : clock and synchronous active-high reset
//   in_head    : input record (valid + idata)
//   in_ready   : record accepted when in_head.valid && in_ready
//   flush      : request to emit the current partial frame
//   out_data   : frame word, slot k at bits [4k+3:4k], unused slots zero
//   out_count  : number of valid slots (1..HDSIZE)
//   out_valid  : frame available
//   out_ready  : consumer accepts on out_valid && out_ready
// All outputs are registered.
module head_frame_packer
    import head_package::*;
#(
    parameter int unsigned HDSIZE  = head_package::HDSIZE,
    parameter int unsigned TIMEOUT = head_package::HDTIMEOUT,
    parameter int unsigned CW      = $clog2(HDSIZE + 1)
) (
    input  logic                clock,
    input  logic                rst,
    input  s_head               in_head,
    output logic                in_ready,
    input  logic                flush,
    output logic [HDSIZE*4-1:0] out_data,
    output logic [CW-1:0]       out_count,
    output logic                out_valid,
    input  logic                out_ready
);

    e_pack_state         state;
    logic [CW-1:0]       fill;
    logic [HDSIZE*4-1:0] slots;

    logic [CW-1:0]       fill_next;
    logic [HDSIZE*4-1:0] slots_next;
    logic                accept;
    logic                idle_hit;
    logic                go_emit;

    // in_ready is high exactly in COLLECT, so the state alone qualifies an accept.
    assign accept = (state == COLLECT) && in_head.valid;

    head_idle_timer #(
        .LIMIT (TIMEOUT),
        .W     (8)
    ) u_idle_timer (
        .clock  (clock),
        .rst    (rst),
        .clear  (accept || (fill == '0) || (state == EMIT)),
        .enable (state == COLLECT),
        .hit    (idle_hit)
    );

    always_comb begin
        slots_next = slots;
        fill_next  = fill;
        if (accept) begin
            for (int k = 0; k < int'(HDSIZE); k++) begin
                if (fill == CW'(k)) begin
                    slots_next[k*4 +: 4] = in_head.idata;
                end
            end
            fill_next = fill + CW'(1);
        end
    end

    // Evaluated after this cycle's accept; fill_next > 0 keeps empty frames out.
    assign go_emit = (fill_next == CW'(HDSIZE)) ||
                     ((fill_next != '0) && (flush || idle_hit));

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= COLLECT;
            fill      <= '0;
            slots     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    slots <= slots_next;
                    fill  <= fill_next;
                    if (go_emit) begin
                        state     <= EMIT;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= slots_next;
                        out_count <= fill_next;
                    end
                end
                EMIT: begin
                    // Frame held until taken; flush and new records are ignored here.
                    if (out_ready) begin
                        state     <= COLLECT;
                        fill      <= '0;
                        slots     <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_count <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: doc/head_frame_packer.md
# head_frame_packer

Collects a stream of `s_head` nibble records from `head_package` into one frame word of `HDSIZE` nibbles. It then presents the frame to the next stage with a valid/ready handshake. It sits directly downstream of the producer of `s_head` records and provides their single back-pressure point. Partial frames are emitted on an explicit flush or after an idle timeout.

## Interface
- `HDSIZE`, default `head_package::HDSIZE` (8): nibbles per frame.
- `TIMEOUT`, default 16: idle cycles before a partial frame is force-emitted; legal range 1..255.
- `CW`, default `$clog2(HDSIZE+1)` (4): width of the fill count.
- `clock`  in  1  single clock for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `in_head`  in  `s_head`  input record; `in_head.valid` qualifies `in_head.idata[3:0]`.
- `in_ready`  out  1  record accepted on a cycle with `in_head.valid && in_ready`.
- `flush`  in  1  single-cycle request to emit the current partial frame.
- `out_data`  out  `HDSIZE*4`  frame word; slot k occupies bits [4k+3:4k].
- `out_count`  out  `CW`  number of valid slots in `out_data` (1..HDSIZE).
- `out_valid`  out  1  frame available.
- `out_ready`  in  1  consumer accepts the frame on `out_valid && out_ready`.

## Operation
- Two states, `COLLECT` and `EMIT` (enum `e_pack_state` in the package).
- `COLLECT`:
  - `in_ready`=1, `out_valid`=0.
  - Each accepted record writes `idata` into slot `fill` and increments `fill`.
  - Slot 0 is the first record received.
- `COLLECT` → `EMIT` on any of these, evaluated after the current cycle's accept:
  - `fill` reaches `HDSIZE`;
  - `flush`=1 with `fill`>0 (counting a record accepted the same cycle);
  - idle counter reaches `TIMEOUT` with `fill`>0.
- `flush` with `fill`=0 and no accept that cycle is ignored. No empty frame is ever emitted.
- Idle counter:
  - clears on every accept and whenever `fill`=0;
  - increments otherwise while in `COLLECT`;
  - saturates at `TIMEOUT`.
- `EMIT`:
  - `in_ready`=0, `out_valid`=1.
  - `out_data` and `out_count` are held stable until the handshake.
  - Unused slots read 0.
- On `out_valid && out_ready`: `fill`, slot storage and idle counter clear, and the state returns to `COLLECT`.
- `flush` asserted while in `EMIT` is ignored. It is not queued.
- Records presented while `in_ready`=0 are not consumed. The producer holds them.

## Timing
- Reset values:
  - state `COLLECT`, `fill`=0, idle counter 0;
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `out_count`=0.
- Reset mid-frame discards the partial frame. Reset during `EMIT` drops `out_valid` on the next edge.
- Latency:
  - record accepted on cycle N completes the frame or coincides with `flush` → `out_valid` high on cycle N+1;
  - timeout → `out_valid` high on the cycle after the counter reaches `TIMEOUT`. With `TIMEOUT`=16 and the last accept on cycle N, that is cycle N+17.
- `in_ready` is low for the whole of `EMIT`, including the handshake cycle, and returns high on the cycle after it.
- Minimum frame period for full frames with `out_ready` held at 1 is `HDSIZE`+1 cycles.
- All outputs are registered. There is no combinational path from `in_head`, `flush` or `out_ready` to any output.

## Structure
- Add to `head_package`:
  - enum `e_pack_state`;
  - struct `s_head_frame` with `logic [HDSIZE*4-1:0] data` and `logic [3:0] count`;
  - constant `HDTIMEOUT` = 16.
- `HDSIZE` remains the single source of frame size.
- One sub-module is natural: `head_idle_timer`, a saturating counter with clear, enable and a `hit` output.
- Slot storage and the FSM live in the top module.

## Test plan
- 8 consecutive records, idata 0x1..0x8, `out_ready`=1 → one frame with `out_data`=0x87654321, `out_count`=8, `out_valid` high one cycle after the 8th accept.
- 3 records 0xA, 0xB, 0xC, then idle → after 16 idle cycles, frame `out_data`=0x00000CBA, `out_count`=3.
- 2 records, with `flush` on the same cycle as the 2nd accept → frame `out_count`=2 on the next cycle; `flush` with `fill`=0 produces no frame.
- Full frame with `out_ready`=0 for 5 cycles → `out_valid` and data stable for all 5 cycles; `in_ready`=0; held records are accepted only after the handshake, with none lost or duplicated.
- `rst` pulsed after 5 records → no frame emitted; the next 8 records form a clean frame starting at slot 0.
- Random valid/ready stress, 10k records → concatenated frame slots equal the input sequence.
